// File: rtl/fir_poly_pkg.sv
// Shared FSM state type and width helpers for the polyphase bank MAC.
package fir_poly_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StOut
  } poly_state_e;

  // Index width for an n-entry table; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Accumulator width that holds a full-precision sum of len products.
  function automatic int unsigned acc_width(input int unsigned in_w,
                                            input int unsigned tap_w,
                                            input int unsigned len);
    return in_w + tap_w + idx_width(len);
  endfunction

endpackage

// File: rtl/poly_bank_outfmt.sv
// Output reduction for the polyphase bank MAC: arithmetic shift, then either
// round-half-up plus saturation (POLY_BANK_ROUND_EN defined) or plain wrap.
module poly_bank_outfmt #(
  parameter int unsigned ACC_WIDTH    = 30,
  parameter int unsigned OUTPUT_WIDTH = 24,
  parameter int unsigned OUT_SHIFT    = 0
) (
  input  logic signed [ACC_WIDTH-1:0]    acc,
  output logic signed [OUTPUT_WIDTH-1:0] dout,
  output logic                           dout_sat
);

  // One guard bit above both widths so rounding and range checks never overflow.
  localparam int unsigned XW = (ACC_WIDTH > OUTPUT_WIDTH) ? ACC_WIDTH + 1 : OUTPUT_WIDTH + 1;

  logic signed [XW-1:0] acc_ext;
  logic signed [XW-1:0] shifted;

  assign acc_ext = {{(XW - ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
  assign shifted = acc_ext >>> OUT_SHIFT;

`ifdef POLY_BANK_ROUND_EN
  logic                       round_bit;
  logic signed [XW-1:0]       rounded;
  logic [XW-OUTPUT_WIDTH:0]   upper;
  logic                       in_range;

  if (OUT_SHIFT > 0) begin : g_round
    assign round_bit = acc_ext[OUT_SHIFT-1];
  end else begin : g_no_round
    assign round_bit = 1'b0;
  end

  assign rounded  = shifted + {{(XW - 1){1'b0}}, round_bit};
  // Value fits when every bit from the output sign bit upward agrees.
  assign upper    = rounded[XW-1:OUTPUT_WIDTH-1];
  assign in_range = (&upper) | ~(|upper);

  // Clamp to the signed output range when the rounded value does not fit.
  always_comb begin
    dout     = rounded[OUTPUT_WIDTH-1:0];
    dout_sat = 1'b0;
    if (!in_range) begin
      dout_sat = 1'b1;
      dout     = rounded[XW-1] ? {1'b1, {(OUTPUT_WIDTH - 1){1'b0}}}
                               : {1'b0, {(OUTPUT_WIDTH - 1){1'b1}}};
    end
  end
`else
  logic unused_hi;

  assign dout      = shifted[OUTPUT_WIDTH-1:0];
  assign dout_sat  = 1'b0;
  assign unused_hi = ^shifted[XW-1:OUTPUT_WIDTH];
`endif

endmodule

// File: rtl/poly_bank_mac.sv
// Polyphase bank MAC: one BANK_LEN-tap branch, one tap per cycle, valid/ready
// on both sides. Output reduction is selected by POLY_BANK_ROUND_EN
// (defined: round + saturate, undefined: wrap with dout_sat tied low).
module poly_bank_mac
  import fir_poly_pkg::*;
#(
  parameter int unsigned BANK_LEN     = 6,
  parameter int unsigned INPUT_WIDTH  = 12,
  parameter int unsigned TAP_WIDTH    = 16,
  parameter int unsigned OUTPUT_WIDTH = 24,
  parameter int unsigned OUT_SHIFT    = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             din_valid,
  output logic                             din_ready,
  input  logic signed [INPUT_WIDTH-1:0]    din,
  input  logic                             coef_we,
  input  logic [idx_width(BANK_LEN)-1:0]   coef_addr,
  input  logic signed [TAP_WIDTH-1:0]      coef_data,
  output logic                             dout_valid,
  input  logic                             dout_ready,
  output logic signed [OUTPUT_WIDTH-1:0]   dout,
  output logic                             dout_sat
);

  localparam int unsigned AW        = idx_width(BANK_LEN);
  localparam int unsigned AW1       = AW + 1;
  localparam int unsigned ACC_WIDTH = acc_width(INPUT_WIDTH, TAP_WIDTH, BANK_LEN);
  localparam logic [AW-1:0] KLast    = AW'(BANK_LEN - 1);
  localparam logic [AW:0]   BankLenW = AW1'(BANK_LEN);

  poly_state_e                    state_q, state_d;
  logic [AW-1:0]                  k_q, k_d;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic signed [INPUT_WIDTH-1:0]  x_q [BANK_LEN];
  logic signed [INPUT_WIDTH-1:0]  x_d [BANK_LEN];
  logic signed [TAP_WIDTH-1:0]    coef_q [BANK_LEN];
  logic signed [TAP_WIDTH-1:0]    coef_d [BANK_LEN];
  logic signed [OUTPUT_WIDTH-1:0] dout_q, dout_d;
  logic                           dout_valid_q, dout_valid_d;
  logic                           dout_sat_q, dout_sat_d;

  logic signed [ACC_WIDTH-1:0]    x_ext, c_ext, prod, acc_sum;
  logic signed [OUTPUT_WIDTH-1:0] fmt_dout;
  logic                           fmt_sat;

  // Current tap product, widened first so the running sum cannot overflow.
  always_comb begin
    x_ext   = {{(ACC_WIDTH - INPUT_WIDTH){x_q[k_q][INPUT_WIDTH-1]}}, x_q[k_q]};
    c_ext   = {{(ACC_WIDTH - TAP_WIDTH){coef_q[k_q][TAP_WIDTH-1]}}, coef_q[k_q]};
    prod    = x_ext * c_ext;
    acc_sum = acc_q + prod;
  end

  // The final sum is formatted straight from acc_sum so dout registers on the
  // last MAC edge, keeping the loop at BANK_LEN+2 cycles per sample.
  poly_bank_outfmt #(
    .ACC_WIDTH   (ACC_WIDTH),
    .OUTPUT_WIDTH(OUTPUT_WIDTH),
    .OUT_SHIFT   (OUT_SHIFT)
  ) u_outfmt (
    .acc     (acc_sum),
    .dout    (fmt_dout),
    .dout_sat(fmt_sat)
  );

  // Next-state logic: coefficient writes, sample intake, MAC sequencing, output hold.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    acc_d        = acc_q;
    x_d          = x_q;
    coef_d       = coef_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_sat_d   = dout_sat_q;

    // MAC reads coef_q, so a same-cycle write is seen only from the next cycle.
    if (coef_we && ({1'b0, coef_addr} < BankLenW)) begin
      coef_d[coef_addr] = coef_data;
    end

    unique case (state_q)
      StIdle: begin
        if (din_valid) begin
          for (int unsigned i = 1; i < BANK_LEN; i++) begin
            x_d[i] = x_q[i-1];
          end
          x_d[0]  = din;
          acc_d   = '0;
          k_d     = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_sum;
        k_d   = k_q + 1'b1;
        if (k_q == KLast) begin
          k_d          = '0;
          dout_d       = fmt_dout;
          dout_sat_d   = fmt_sat;
          dout_valid_d = 1'b1;
          state_d      = StOut;
        end
      end
      StOut: begin
        if (dout_ready) begin
          dout_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      k_q          <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_sat_q   <= 1'b0;
      for (int unsigned i = 0; i < BANK_LEN; i++) begin
        x_q[i]    <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_sat_q   <= dout_sat_d;
      x_q          <= x_d;
      coef_q       <= coef_d;
    end
  end

  assign din_ready  = rst_n & (state_q == StIdle);
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign dout_sat   = dout_sat_q;

endmodule

// File: tb/tb_poly_bank_mac.sv
// Scoreboard bench for poly_bank_mac (BANK_LEN=4). A second instance with
// OUT_SHIFT=2 shares all inputs and is checked only on the rounding vectors.
module tb_poly_bank_mac;

  localparam int BL = 4;

  typedef struct {
    logic signed [23:0] d;
    logic               s;
    bit                 csh;
    logic signed [23:0] sh;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               din_valid;
  logic               din_ready;
  logic signed [11:0] din;
  logic               coef_we;
  logic [1:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic               dout_valid;
  logic               dout_ready;
  logic signed [23:0] dout;
  logic               dout_sat;
  logic               sh_din_ready;
  logic               sh_valid;
  logic signed [23:0] sh_dout;
  logic               sh_sat;

  exp_t sb[$];
  int   acc_times[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  poly_bank_mac #(
    .BANK_LEN(BL), .INPUT_WIDTH(12), .TAP_WIDTH(16), .OUTPUT_WIDTH(24), .OUT_SHIFT(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout), .dout_sat(dout_sat)
  );

  poly_bank_mac #(
    .BANK_LEN(BL), .INPUT_WIDTH(12), .TAP_WIDTH(16), .OUTPUT_WIDTH(24), .OUT_SHIFT(2)
  ) u_sh (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_ready(sh_din_ready), .din(din),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .dout_valid(sh_valid), .dout_ready(dout_ready), .dout(sh_dout), .dout_sat(sh_sat)
  );

  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event, want none", name);
  endtask

  // Accept recorder: cycle index of each input handshake edge.
  initial forever begin
    @(posedge clk);
    if (rst_n && din_valid && din_ready) acc_times.push_back(cyc);
    cyc = cyc + 1;
  end

  // Monitor: latency, hold-while-stalled and scoreboard comparison on handshake.
  initial begin : monitor
    bit   prev_v, stall_prev, held_s;
    logic signed [23:0] held_d;
    exp_t e;
    prev_v = 0; stall_prev = 0; held_s = 0; held_d = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_v = 0;
        stall_prev = 0;
      end else begin
        if (dout_valid && !prev_v) begin
          if (acc_times.size() == 0) fail_now("latency_no_accept");
          else chk("latency", cyc - acc_times.pop_front(), BL + 1);
        end
        if (dout_valid) chk("din_ready_busy", din_ready, 0);
        if (dout_valid && stall_prev) begin
          chk("hold_dout", dout, held_d);
          chk("hold_sat", dout_sat, held_s);
        end
        if (dout_valid && dout_ready) begin
          if (sb.size() == 0) fail_now("unexpected_out");
          else begin
            e = sb.pop_front();
            chk("dout", dout, e.d);
            chk("dout_sat", dout_sat, e.s);
            chk("sh_valid", sh_valid, 1);
            if (e.csh) begin
              chk("sh_dout", sh_dout, e.sh);
              chk("sh_sat", sh_sat, 0);
            end
          end
        end
        stall_prev = dout_valid && !dout_ready;
        held_d = dout;
        held_s = dout_sat;
        prev_v = dout_valid;
      end
    end
  end

  // Issue one sample; returns at the negedge right after the accepting edge.
  task automatic send(input int s, input bit push, input int d, input bit ds,
                      input bit csh, input int shd);
    exp_t e;
    bit ok;
    e.d = 24'(d); e.s = ds; e.csh = csh; e.sh = 24'(shd);
    if (push) sb.push_back(e);
    din = 12'(s);
    din_valid = 1'b1;
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      if (din_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    din_valid = 1'b0;
    chk("accept_in_time", ok, 1);
  endtask

  task automatic wr_coef(input int a, input int v);
    coef_we = 1'b1;
    coef_addr = 2'(a);
    coef_data = 16'(v);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic load4(input int c0, input int c1, input int c2, input int c3);
    wr_coef(0, c0);
    wr_coef(1, c1);
    wr_coef(2, c2);
    wr_coef(3, c3);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int t = 0; t < 500; t++) begin
      if (sb.size() == 0 && !dout_valid) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("drain_in_time", ok, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want test done");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; din_valid = 0; din = '0; coef_we = 0; coef_addr = '0; coef_data = '0;
    dout_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout_sat", dout_sat, 0);
    chk("rst_din_ready", din_ready, 0);
    @(negedge clk);
    rst_n = 1;
    #2;
    chk("din_ready_after_rst", din_ready, 1);

    // Coefficients reset to zero: everything out is 0; also flushes history.
    send(5, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(0, 1, 0, 0, 0, 0);
    drain();

    // Impulse response with coef {1,2,3,4}.
    load4(1, 2, 3, 4);
    send(1, 1, 1, 0, 0, 0);
    send(0, 1, 2, 0, 0, 0);
    send(0, 1, 3, 0, 0, 0);
    send(0, 1, 4, 0, 0, 0);
    send(0, 1, 0, 0, 0, 0);

    // Constant input 100 builds up the running sum.
    send(100, 1, 100, 0, 0, 0);
    send(100, 1, 300, 0, 0, 0);
    send(100, 1, 600, 0, 0, 0);
    send(100, 1, 1000, 0, 0, 0);
    send(100, 1, 1000, 0, 0, 0);
    drain();

    // Write coef[1] during the MAC cycle that reads it: old value (2) is used.
    send(100, 1, 1000, 0, 0, 0);
    @(negedge clk);
    wr_coef(1, 50);
    drain();
    send(100, 1, 5800, 0, 0, 0);
    drain();
    wr_coef(1, 2);

    // Back-pressure: 5 stalled cycles in OUT; next sample waits with din_valid high.
    dout_ready = 0;
    fork
      begin
        send(100, 1, 1000, 0, 0, 0);
        send(100, 1, 1000, 0, 0, 0);
      end
      begin : release_ready
        int n;
        n = 0;
        while (!dout_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        repeat (5) @(negedge clk);
        dout_ready = 1;
      end
    join
    drain();

    // Abort: reset in the second MAC cycle; nothing may come out.
    send(7, 1, 907, 0, 0, 0);
    send(7, 1, 721, 0, 0, 0);
    drain();
    send(5, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 0;
    sb.delete();
    acc_times.delete();
    #1;
    chk("din_ready_in_rst", din_ready, 0);
    repeat (2) @(negedge clk);
    chk("abort_no_valid", dout_valid, 0);
    rst_n = 1;
    repeat (10) @(negedge clk);
    chk("abort_still_no_valid", dout_valid, 0);
    load4(1, 2, 3, 4);
    send(1, 1, 1, 0, 0, 0);
    send(0, 1, 2, 0, 0, 0);
    send(0, 1, 3, 0, 0, 0);
    send(0, 1, 4, 0, 0, 0);
    send(0, 1, 0, 0, 0, 0);
    drain();

    // Full-scale inputs: saturate with rounding build, wrap otherwise.
    load4(32767, 32767, 32767, 32767);
`ifdef POLY_BANK_ROUND_EN
    for (int i = 0; i < 4; i++) send(2047, 1, 8388607, 1, 0, 0);
`else
    send(2047, 1, -34815, 0, 0, 0);
    send(2047, 1, -69630, 0, 0, 0);
    send(2047, 1, -104445, 0, 0, 0);
    send(2047, 1, -139260, 0, 0, 0);
`endif
    drain();

    // Shift by 2 on acc = +6 / -6.
    load4(6, 0, 0, 0);
`ifdef POLY_BANK_ROUND_EN
    send(1, 1, 6, 0, 1, 2);
    send(-1, 1, -6, 0, 1, -1);
`else
    send(1, 1, 6, 0, 1, 1);
    send(-1, 1, -6, 0, 1, -2);
`endif
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
